// File: rtl/miriscv_dmem_responder.sv
// Data-memory responder: services one load or store at a time from an internal
// word-addressed RAM and answers with a one-cycle rvalid after LATENCY cycles.
package miriscv_pkg;
    parameter int XLEN = 32;
endpackage

module miriscv_dmem_responder #(
    parameter int                        XLEN      = miriscv_pkg::XLEN,
    parameter int unsigned               MEM_WORDS = 1024,
    parameter logic [XLEN-1:0]           BASE_ADDR = '0,
    parameter int unsigned               LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 data_req_i,
    input  logic                 data_we_i,
    input  logic [XLEN/8-1:0]    data_be_i,
    input  logic [XLEN-1:0]      data_addr_i,
    input  logic [XLEN-1:0]      data_wdata_i,
    output logic                 data_rvalid_o,
    output logic [XLEN-1:0]      data_rdata_o
);

    localparam int              IDX_W     = $clog2(MEM_WORDS);
    localparam int              BE_W      = XLEN / 8;
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * 4);
    localparam logic [3:0]      LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 capture;

    logic                 we_q;
    logic [BE_W-1:0]      be_q;
    logic [XLEN-1:0]      addr_q;
    logic [XLEN-1:0]      wdata_q;

    logic                 rvalid_q;
    logic [XLEN-1:0]      rdata_q;

    logic [XLEN-1:0]      mem [MEM_WORDS];

    logic                 sel_we;
    logic [XLEN-1:0]      sel_offset;
    logic                 sel_in_range;
    logic [IDX_W-1:0]     sel_idx;

    // In IDLE the request fields are still on the inputs (LATENCY==1 reads them
    // directly); afterwards the captured copies are used.
    assign sel_we       = (state_q == IDLE) ? data_we_i : we_q;
    assign sel_offset   = ((state_q == IDLE) ? data_addr_i : addr_q) - BASE_ADDR;
    assign sel_in_range = (sel_offset < MEM_BYTES);
    assign sel_idx      = sel_offset[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    capture = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // A dropped request while waiting is an LSU kill.
                if (!data_req_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= (state_d == RESP);
            if (capture) begin
                we_q    <= data_we_i;
                be_q    <= data_be_i;
                addr_q  <= data_addr_i;
                wdata_q <= data_wdata_i;
            end
            if ((state_d == RESP) && !sel_we) begin
                rdata_q <= sel_in_range ? mem[sel_idx] : '0;
            end
        end
    end

    // Stores commit on the edge that leaves RESP, so a reset during the
    // transaction (which forces IDLE) suppresses the write.
    always_ff @(posedge clk_i) begin
        if ((state_q == RESP) && we_q && sel_in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_q[i]) begin
                    mem[sel_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

endmodule
